reg_scoreboard: RTL and testbench

- In-order in-flight destination tracker with a result buffer, serving the ID stage of the 5-stage LoongArch32 pipeline.
- Replaces the per-stage dest compares (es/ms/ws) with tagged entries:
  - an entry is allocated when a register-writing instruction leaves ID;
  - the entry captures its result when EX/MEM produce it;
  - the entry retires at WB commit.
- Gives ID per-source forwarding data or a stall request, independent of pipeline bubbles.

---
 rtl/reg_scoreboard_pkg.sv | 20 ++
 rtl/sb_youngest_match.sv | 49 ++++
 rtl/reg_scoreboard.sv | 152 +++++++++++++++
 tb/tb_reg_scoreboard.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_scoreboard_pkg.sv
// reg_scoreboard_pkg
// Shared definitions for the in-flight destination scoreboard:
//   SB_DEPTH / SB_TAG_W  default entry count and tag width
//   REG_ZERO             architectural zero register (never tracked)
//   sb_entry_t           one in-flight entry (valid, dest, ready, data)
package reg_scoreboard_pkg;

  localparam int SB_DEPTH = 4;
  localparam int SB_TAG_W = 2;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic        valid;
    logic [4:0]  dest;
    logic        ready;
    logic [31:0] data;
  } sb_entry_t;

endpackage

// File: rtl/sb_youngest_match.sv
// sb_youngest_match
// Finds the youngest valid entry whose dest equals src_addr, walking by age
// from head. A src_addr of REG_ZERO never matches.
// Ports:
//   entries   in   entry vector, indexed by tag
//   head      in   oldest entry index
//   count     in   number of occupied entries
//   src_addr  in   register being looked up (REG_ZERO when unused)
//   found     out  a matching entry exists
//   index     out  tag of the youngest match
//   ready     out  youngest match holds its result
//   data      out  stored data of the youngest match (0 when none)
module sb_youngest_match
  import reg_scoreboard_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH,
  parameter int TAG_W = SB_TAG_W
) (
  input  sb_entry_t [DEPTH-1:0] entries,
  input  logic [TAG_W-1:0]      head,
  input  logic [TAG_W:0]        count,
  input  logic [4:0]            src_addr,
  output logic                  found,
  output logic [TAG_W-1:0]      index,
  output logic                  ready,
  output logic [31:0]           data
);

  logic [TAG_W-1:0] idx;

  // Later (younger) ages overwrite earlier hits, so the last match wins.
  always_comb begin
    found = 1'b0;
    index = '0;
    idx   = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head + TAG_W'(k);
      if (((TAG_W+1)'(k) < count) && entries[idx].valid &&
          (entries[idx].dest == src_addr) && (src_addr != REG_ZERO)) begin
        found = 1'b1;
        index = idx;
      end
    end
  end

  assign ready = found & entries[index].ready;
  assign data  = found ? entries[index].data : '0;

endmodule

// File: rtl/reg_scoreboard.sv
// reg_scoreboard
// In-order in-flight destination tracker with result buffer for the ID stage.
// Entries are allocated at ID->EX issue, filled by EX/MEM result writes and
// retired at WB commit. ID gets per-source forwarding data or a stall.
// Optional build macro: SB_RESULT_BYPASS_EN -- lookup also takes a
// same-cycle result write to the winning entry.
// Ports:
//   clk, reset                    clock, synchronous active-high reset
//   src{1,2}_addr/_used           ID source registers and use flags
//   src{1,2}_hit/_data            forward select and forwarded value
//   stall                         a used source's youngest producer not ready
//   issue_ready/issue_fire        allocation handshake (issue_ready = !full)
//   issue_dest, issue_tag         destination allocated, tag it receives
//   res_wr_valid/_tag/_data       result capture into an entry
//   commit_fire, commit_dest      WB retire of the head entry
//   count                         occupied entries
//   err                           sticky protocol error
module reg_scoreboard
  import reg_scoreboard_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH,
  parameter int TAG_W = SB_TAG_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       src1_addr,
  input  logic             src1_used,
  input  logic [4:0]       src2_addr,
  input  logic             src2_used,
  output logic             src1_hit,
  output logic [31:0]      src1_data,
  output logic             src2_hit,
  output logic [31:0]      src2_data,
  output logic             stall,
  output logic             issue_ready,
  input  logic             issue_fire,
  input  logic [4:0]       issue_dest,
  output logic [TAG_W-1:0] issue_tag,
  input  logic             res_wr_valid,
  input  logic [TAG_W-1:0] res_wr_tag,
  input  logic [31:0]      res_wr_data,
  input  logic             commit_fire,
  input  logic [4:0]       commit_dest,
  output logic [TAG_W:0]   count,
  output logic             err
);

  localparam logic [TAG_W:0]   FULL_COUNT = (TAG_W+1)'(DEPTH);
  localparam logic [TAG_W-1:0] TAG_ONE    = TAG_W'(1);

  sb_entry_t [DEPTH-1:0] entries;
  logic [TAG_W-1:0]      head;
  logic [TAG_W-1:0]      tail;
  logic [TAG_W:0]        count_q;
  logic                  err_q;

  logic full, empty;
  logic issue_ok, commit_ok, commit_bad, res_bad, err_set;

  assign full  = (count_q == FULL_COUNT);
  assign empty = (count_q == '0);

  assign issue_ok   = issue_fire & ~full;
  assign commit_ok  = commit_fire & ~empty;
  // A bad commit still pops; it only flags the error.
  assign commit_bad = commit_ok & ((commit_dest != entries[head].dest) | ~entries[head].ready);
  // The tail slot is always invalid while not full, so a result aimed at the
  // issuing slot lands here as well and the issue overwrites it below.
  assign res_bad    = res_wr_valid & ~entries[res_wr_tag].valid;
  assign err_set    = (issue_fire & full) | (commit_fire & empty) | commit_bad | res_bad;

  always_ff @(posedge clk) begin
    if (reset) begin
      entries <= '0;
      head    <= '0;
      tail    <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (res_wr_valid && entries[res_wr_tag].valid) begin
        entries[res_wr_tag].ready <= 1'b1;
        entries[res_wr_tag].data  <= res_wr_data;
      end
      if (issue_ok) begin
        entries[tail].valid <= 1'b1;
        entries[tail].dest  <= issue_dest;
        entries[tail].ready <= 1'b0;
        entries[tail].data  <= '0;
        tail                <= tail + TAG_ONE;
      end
      if (commit_ok) begin
        entries[head] <= '0;
        head          <= head + TAG_ONE;
      end
      count_q <= count_q + {{TAG_W{1'b0}}, issue_ok} - {{TAG_W{1'b0}}, commit_ok};
      if (err_set) err_q <= 1'b1;
    end
  end

  logic [4:0]       q1_addr, q2_addr;
  logic             m1_found, m2_found, m1_ready, m2_ready;
  logic [TAG_W-1:0] m1_index, m2_index;
  logic [31:0]      m1_data, m2_data;
  logic             byp1, byp2;

  assign q1_addr = src1_used ? src1_addr : REG_ZERO;
  assign q2_addr = src2_used ? src2_addr : REG_ZERO;

  sb_youngest_match #(.DEPTH(DEPTH), .TAG_W(TAG_W)) u_match_src1 (
    .entries  (entries),
    .head     (head),
    .count    (count_q),
    .src_addr (q1_addr),
    .found    (m1_found),
    .index    (m1_index),
    .ready    (m1_ready),
    .data     (m1_data)
  );

  sb_youngest_match #(.DEPTH(DEPTH), .TAG_W(TAG_W)) u_match_src2 (
    .entries  (entries),
    .head     (head),
    .count    (count_q),
    .src_addr (q2_addr),
    .found    (m2_found),
    .index    (m2_index),
    .ready    (m2_ready),
    .data     (m2_data)
  );

`ifdef SB_RESULT_BYPASS_EN
  assign byp1 = res_wr_valid & m1_found & (res_wr_tag == m1_index);
  assign byp2 = res_wr_valid & m2_found & (res_wr_tag == m2_index);
`else
  assign byp1 = 1'b0;
  assign byp2 = 1'b0;
`endif

  assign src1_hit  = m1_found & (m1_ready | byp1);
  assign src2_hit  = m2_found & (m2_ready | byp2);
  assign src1_data = byp1 ? res_wr_data : (m1_ready ? m1_data : '0);
  assign src2_data = byp2 ? res_wr_data : (m2_ready ? m2_data : '0);

  assign stall = (m1_found & ~m1_ready & ~byp1) | (m2_found & ~m2_ready & ~byp2);

  // Registered state only: a same-cycle commit does not free a slot early.
  assign issue_ready = ~full;
  assign issue_tag   = tail;
  assign count       = count_q;
  assign err         = err_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// tb_reg_scoreboard
// Table-driven bench for reg_scoreboard: each row drives one cycle of inputs
// and lists the outputs expected in that cycle (before the clock edge),
// followed by hand-written wrap-around and error sequences.
module tb_reg_scoreboard;

`ifdef SB_RESULT_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  localparam bit NB = ~BYP;

  logic        clk;
  logic        reset;
  logic [4:0]  src1_addr, src2_addr;
  logic        src1_used, src2_used;
  logic        src1_hit, src2_hit;
  logic [31:0] src1_data, src2_data;
  logic        stall;
  logic        issue_ready;
  logic        issue_fire;
  logic [4:0]  issue_dest;
  logic [1:0]  issue_tag;
  logic        res_wr_valid;
  logic [1:0]  res_wr_tag;
  logic [31:0] res_wr_data;
  logic        commit_fire;
  logic [4:0]  commit_dest;
  logic [2:0]  count;
  logic        err;

  reg_scoreboard dut (
    .clk          (clk),
    .reset        (reset),
    .src1_addr    (src1_addr),
    .src1_used    (src1_used),
    .src2_addr    (src2_addr),
    .src2_used    (src2_used),
    .src1_hit     (src1_hit),
    .src1_data    (src1_data),
    .src2_hit     (src2_hit),
    .src2_data    (src2_data),
    .stall        (stall),
    .issue_ready  (issue_ready),
    .issue_fire   (issue_fire),
    .issue_dest   (issue_dest),
    .issue_tag    (issue_tag),
    .res_wr_valid (res_wr_valid),
    .res_wr_tag   (res_wr_tag),
    .res_wr_data  (res_wr_data),
    .commit_fire  (commit_fire),
    .commit_dest  (commit_dest),
    .count        (count),
    .err          (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          rst;
    bit          iss;
    logic [4:0]  idest;
    bit          rwv;
    logic [1:0]  rtag;
    logic [31:0] rdata;
    bit          cmt;
    logic [4:0]  cdest;
    logic [4:0]  s1a;
    bit          s1u;
    logic [4:0]  s2a;
    bit          s2u;
    bit          e_stall;
    bit          e_h1;
    logic [31:0] e_d1;
    bit          e_h2;
    logic [31:0] e_d2;
    logic [2:0]  e_cnt;
    bit          e_rdy;
    logic [1:0]  e_tag;
    bit          e_err;
  } vec_t;

  vec_t vecs[$];
  int   n_pass;
  int   n_total;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic clear_inputs();
    issue_fire   = 1'b0;
    issue_dest   = 5'd0;
    res_wr_valid = 1'b0;
    res_wr_tag   = 2'd0;
    res_wr_data  = 32'h0;
    commit_fire  = 1'b0;
    commit_dest  = 5'd0;
    src1_addr    = 5'd0;
    src1_used    = 1'b0;
    src2_addr    = 5'd0;
    src2_used    = 1'b0;
  endtask

  task automatic apply(input vec_t v);
    reset        = v.rst;
    issue_fire   = v.iss;
    issue_dest   = v.idest;
    res_wr_valid = v.rwv;
    res_wr_tag   = v.rtag;
    res_wr_data  = v.rdata;
    commit_fire  = v.cmt;
    commit_dest  = v.cdest;
    src1_addr    = v.s1a;
    src1_used    = v.s1u;
    src2_addr    = v.s2a;
    src2_used    = v.s2u;
  endtask

  logic [1:0]  wt;
  logic [4:0]  wd;
  logic [31:0] wdata;

  initial begin
    n_pass  = 0;
    n_total = 0;
    reset   = 1'b1;
    clear_inputs();

    // rst iss idest rwv rtag rdata cmt cdest | s1a s1u s2a s2u | stall h1 d1 h2 d2 | cnt rdy tag err
    vecs.push_back('{1'b0,1'b0,5'd0,1'b0,2'd0,32'h0,1'b0,5'd0, 5'd5,1'b1,5'd0,1'b0, 1'b0,1'b0,32'h0,1'b0,32'h0, 3'd0,1'b1,2'd0,1'b0}); // 0 idle after reset
    vecs.push_back('{1'b0,1'b1,5'd5,1'b0,2'd0,32'h0,1'b0,5'd0, 5'd5,1'b1,5'd0,1'b0, 1'b0,1'b0,32'h0,1'b0,32'h0, 3'd0,1'b1,2'd0,1'b0}); // 1 issue 5, not yet visible
    vecs.push_back('{1'b0,1'b0,5'd0,1'b0,2'd0,32'h0,1'b0,5'd0, 5'd5,1'b1,5'd0,1'b0, 1'b1,1'b0,32'h0,1'b0,32'h0, 3'd1,1'b1,2'd1,1'b0}); // 2 stall on 5
    vecs.push_back('{1'b0,1'b0,5'd0,1'b1,2'd0,32'h1234,1'b0,5'd0, 5'd5,1'b1,5'd0,1'b0, NB,BYP,(BYP ? 32'h1234 : 32'h0),1'b0,32'h0, 3'd1,1'b1,2'd1,1'b0}); // 3 result write cycle
    vecs.push_back('{1'b0,1'b0,5'd0,1'b0,2'd0,32'h0,1'b0,5'd0, 5'd5,1'b1,5'd5,1'b0, 1'b0,1'b1,32'h1234,1'b0,32'h0, 3'd1,1'b1,2'd1,1'b0}); // 4 forward; unused src2 no match
    vecs.push_back('{1'b0,1'b1,5'd7,1'b0,2'd0,32'h0,1'b0,5'd0, 5'd5,1'b1,5'd0,1'b1, 1'b0,1'b1,32'h1234,1'b0,32'h0, 3'd1,1'b1,2'd1,1'b0}); // 5 issue 7 (tag1), r0 no match
    vecs.push_back('{1'b0,1'b1,5'd7,1'b1,2'd1,32'hAAAA,1'b0,5'd0, 5'd7,1'b1,5'd0,1'b0, NB,BYP,(BYP ? 32'hAAAA : 32'h0),1'b0,32'h0, 3'd2,1'b1,2'd2,1'b0}); // 6 issue 7 (tag2), wr tag1
    vecs.push_back('{1'b0,1'b0,5'd0,1'b1,2'd2,32'hBBBB,1'b0,5'd0, 5'd7,1'b1,5'd5,1'b1, NB,BYP,(BYP ? 32'hBBBB : 32'h0),1'b1,32'h1234, 3'd3,1'b1,2'd3,1'b0}); // 7 youngest 7 not ready
    vecs.push_back('{1'b0,1'b0,5'd0,1'b0,2'd0,32'h0,1'b1,5'd5, 5'd7,1'b1,5'd5,1'b1, 1'b0,1'b1,32'hBBBB,1'b1,32'h1234, 3'd3,1'b1,2'd3,1'b0}); // 8 youngest wins; head visible on commit
    vecs.push_back('{1'b0,1'b0,5'd0,1'b0,2'd0,32'h0,1'b1,5'd7, 5'd7,1'b1,5'd5,1'b1, 1'b0,1'b1,32'hBBBB,1'b0,32'h0, 3'd2,1'b1,2'd3,1'b0}); // 9 commit older 7, still B
    vecs.push_back('{1'b0,1'b1,5'd3,1'b0,2'd0,32'h0,1'b0,5'd0, 5'd7,1'b1,5'd0,1'b0, 1'b0,1'b1,32'hBBBB,1'b0,32'h0, 3'd1,1'b1,2'd3,1'b0}); // 10 issue 3 (tag3)
    vecs.push_back('{1'b0,1'b1,5'd4,1'b0,2'd0,32'h0,1'b0,5'd0, 5'd3,1'b1,5'd0,1'b0, 1'b1,1'b0,32'h0,1'b0,32'h0, 3'd2,1'b1,2'd0,1'b0}); // 11 issue 4 (tag0)
    vecs.push_back('{1'b0,1'b1,5'd8,1'b0,2'd0,32'h0,1'b0,5'd0, 5'd4,1'b1,5'd0,1'b0, 1'b1,1'b0,32'h0,1'b0,32'h0, 3'd3,1'b1,2'd1,1'b0}); // 12 issue 8 (tag1) -> full
    vecs.push_back('{1'b0,1'b0,5'd0,1'b0,2'd0,32'h0,1'b0,5'd0, 5'd3,1'b1,5'd8,1'b1, 1'b1,1'b0,32'h0,1'b0,32'h0, 3'd4,1'b0,2'd2,1'b0}); // 13 full, both sources wait
    vecs.push_back('{1'b0,1'b1,5'd9,1'b0,2'd0,32'h0,1'b1,5'd7, 5'd7,1'b1,5'd0,1'b0, 1'b0,1'b1,32'hBBBB,1'b0,32'h0, 3'd4,1'b0,2'd2,1'b0}); // 14 issue while full + commit
    vecs.push_back('{1'b0,1'b0,5'd0,1'b0,2'd0,32'h0,1'b0,5'd0, 5'd9,1'b1,5'd7,1'b1, 1'b0,1'b0,32'h0,1'b0,32'h0, 3'd3,1'b1,2'd2,1'b1}); // 15 issue dropped, err
    vecs.push_back('{1'b1,1'b0,5'd0,1'b0,2'd0,32'h0,1'b0,5'd0, 5'd3,1'b1,5'd0,1'b0, 1'b1,1'b0,32'h0,1'b0,32'h0, 3'd3,1'b1,2'd2,1'b1}); // 16 reset mid-queue
    vecs.push_back('{1'b0,1'b0,5'd0,1'b0,2'd0,32'h0,1'b0,5'd0, 5'd3,1'b1,5'd0,1'b0, 1'b0,1'b0,32'h0,1'b0,32'h0, 3'd0,1'b1,2'd0,1'b0}); // 17 cleared
    vecs.push_back('{1'b0,1'b1,5'd3,1'b0,2'd0,32'h0,1'b0,5'd0, 5'd0,1'b0,5'd0,1'b0, 1'b0,1'b0,32'h0,1'b0,32'h0, 3'd0,1'b1,2'd0,1'b0}); // 18 issue 3 (tag0)
    vecs.push_back('{1'b0,1'b0,5'd0,1'b1,2'd0,32'h33,1'b0,5'd0, 5'd0,1'b0,5'd3,1'b1, NB,1'b0,32'h0,BYP,(BYP ? 32'h33 : 32'h0), 3'd1,1'b1,2'd1,1'b0}); // 19 result 0x33
    vecs.push_back('{1'b0,1'b0,5'd0,1'b0,2'd0,32'h0,1'b1,5'd9, 5'd0,1'b0,5'd3,1'b1, 1'b0,1'b0,32'h0,1'b1,32'h33, 3'd1,1'b1,2'd1,1'b0}); // 20 commit wrong dest
    vecs.push_back('{1'b0,1'b0,5'd0,1'b0,2'd0,32'h0,1'b0,5'd0, 5'd0,1'b0,5'd3,1'b1, 1'b0,1'b0,32'h0,1'b0,32'h0, 3'd0,1'b1,2'd1,1'b1}); // 21 popped anyway, err
    vecs.push_back('{1'b1,1'b0,5'd0,1'b0,2'd0,32'h0,1'b0,5'd0, 5'd0,1'b0,5'd0,1'b0, 1'b0,1'b0,32'h0,1'b0,32'h0, 3'd0,1'b1,2'd1,1'b1}); // 22 reset
    vecs.push_back('{1'b0,1'b0,5'd0,1'b0,2'd0,32'h0,1'b0,5'd0, 5'd0,1'b0,5'd0,1'b0, 1'b0,1'b0,32'h0,1'b0,32'h0, 3'd0,1'b1,2'd0,1'b0}); // 23 err cleared

    repeat (2) @(posedge clk);

    foreach (vecs[r]) begin
      @(posedge clk);
      #1 apply(vecs[r]);
      #2;
      check($sformatf("row%0d stall", r),       32'(stall),       32'(vecs[r].e_stall));
      check($sformatf("row%0d src1_hit", r),    32'(src1_hit),    32'(vecs[r].e_h1));
      check($sformatf("row%0d src1_data", r),   src1_data,        vecs[r].e_d1);
      check($sformatf("row%0d src2_hit", r),    32'(src2_hit),    32'(vecs[r].e_h2));
      check($sformatf("row%0d src2_data", r),   src2_data,        vecs[r].e_d2);
      check($sformatf("row%0d count", r),       32'(count),       32'(vecs[r].e_cnt));
      check($sformatf("row%0d issue_ready", r), 32'(issue_ready), 32'(vecs[r].e_rdy));
      check($sformatf("row%0d issue_tag", r),   32'(issue_tag),   32'(vecs[r].e_tag));
      check($sformatf("row%0d err", r),         32'(err),         32'(vecs[r].e_err));
    end

    // Wrap-around: six issue/result/commit rounds, tags cycle 0,1,2,3,0,1.
    for (int i = 1; i <= 6; i++) begin
      wt    = 2'((i - 1) % 4);
      wd    = 5'(i);
      wdata = 32'h100 + 32'(i);
      @(posedge clk);
      #1 clear_inputs();
      reset      = 1'b0;
      issue_fire = 1'b1;
      issue_dest = wd;
      #2 check($sformatf("wrap%0d issue_tag", i), 32'(issue_tag), 32'(wt));
      @(posedge clk);
      #1 clear_inputs();
      res_wr_valid = 1'b1;
      res_wr_tag   = wt;
      res_wr_data  = wdata;
      @(posedge clk);
      #1 clear_inputs();
      commit_fire = 1'b1;
      commit_dest = wd;
      src2_addr   = wd;
      src2_used   = 1'b1;
      #2;
      check($sformatf("wrap%0d src2_hit", i),  32'(src2_hit), 32'h1);
      check($sformatf("wrap%0d src2_data", i), src2_data,     wdata);
      check($sformatf("wrap%0d count", i),     32'(count),    32'h1);
    end

    @(posedge clk);
    #1 clear_inputs();
    #2;
    check("wrap end count", 32'(count),     32'h0);
    check("wrap end err",   32'(err),       32'h0);
    check("wrap end tail",  32'(issue_tag), 32'h2);

    // Commit on an empty queue.
    commit_fire = 1'b1;
    commit_dest = 5'd1;
    @(posedge clk);
    #1 clear_inputs();
    #2;
    check("empty commit err",   32'(err),   32'h1);
    check("empty commit count", 32'(count), 32'h0);

    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    #2 check("reset clears err", 32'(err), 32'h0);

    // Result write to an entry that was never issued.
    res_wr_valid = 1'b1;
    res_wr_tag   = 2'd2;
    res_wr_data  = 32'h5;
    @(posedge clk);
    #1 clear_inputs();
    #2;
    check("invalid res_wr err", 32'(err),   32'h1);
    check("invalid res_wr cnt", 32'(count), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
